// File: rtl/stall_mem_responder_pkg.sv
// Shared types and constants for the stall_mem_responder memory model.
package stall_mem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic        DONE_IDLE  = 1'b0;
  localparam logic        STALL_IDLE = 1'b0;
  localparam logic [15:0] WORD_ZERO  = 16'h0000;

  // Width of the miss-latency down-counter; it holds values up to latency-1.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/stall_mem_array.sv
// 16-bit word store: synchronous write, combinational read, active-low synchronous clear.
module stall_mem_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [15:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**ADDR_BITS];

  // NOTE: clearing every word on reset rules out block-RAM inference; that is
  // accepted here because the model must start from all-zero storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder: last-block hit completes same cycle,
// misses stall for LATENCY cycles and complete in the following cycle.
module stall_mem_responder
  import stall_mem_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int ADDR_BITS  = 8,
  parameter int BLOCK_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int TAG_W = 16 - BLOCK_BITS;
  localparam int CNT_W = cnt_width(LATENCY);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:1]        lat_addr;
  logic [15:0]        lat_data;
  logic               lat_rd, lat_wr;
  logic               last_valid;
  logic [TAG_W-1:0]   last_tag;

  logic               req, illegal, hit;
  logic               capture, retire;
  logic               mem_we;
  logic [ADDR_BITS-1:0] mem_waddr, mem_raddr;
  logic [15:0]        mem_wdata, mem_rdata;

  logic unused_inputs;
  assign unused_inputs = createdump;

  assign req     = Rd | Wr;
  assign illegal = (Rd & Wr) | (Addr[0] & req);
  assign hit     = last_valid && (Addr[15:BLOCK_BITS] == last_tag);

  stall_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      last_valid <= 1'b0;
      last_tag   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        lat_addr <= Addr[15:1];
        lat_data <= DataIn;
        lat_rd   <= Rd;
        lat_wr   <= Wr;
      end
      if (retire) begin
        last_valid <= 1'b1;
        last_tag   <= lat_addr[15:BLOCK_BITS];
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    DataOut   = WORD_ZERO;
    Done      = DONE_IDLE;
    Stall     = STALL_IDLE;
    CacheHit  = 1'b0;
    err       = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = Addr[ADDR_BITS:1];
    mem_wdata = DataIn;
    mem_raddr = Addr[ADDR_BITS:1];

    case (state)
      S_IDLE: begin
        if (req) begin
          if (illegal) begin
            err = 1'b1;
          end else if (hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            mem_we   = Wr;
            if (Rd) DataOut = mem_rdata;
          end else begin
            Stall   = 1'b1;
            capture = 1'b1;
            if (LATENCY == 1) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_BUSY;
              cnt_nxt   = CNT_W'(LATENCY - 1);
            end
          end
        end
      end

      S_BUSY: begin
        Stall   = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      end

      S_DONE: begin
        // The latched request is authoritative; live inputs are ignored here.
        Done      = 1'b1;
        retire    = 1'b1;
        mem_raddr = lat_addr[ADDR_BITS:1];
        mem_waddr = lat_addr[ADDR_BITS:1];
        mem_wdata = lat_data;
        mem_we    = lat_wr;
        if (lat_rd) DataOut = mem_rdata;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
